// File: rtl/serial_tx_buffered.sv
// serial_tx_buffered: FIFO-buffered UART tx; in data/new_data/block, out tx/busy/full/count/overflow
module serial_tx_buffered #(
  parameter int CLK_PER_BIT = 50,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] data,
  input  logic new_data,
  input  logic block,
  output logic tx,
  output logic busy,
  output logic full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int STOP_CYC = STOP_BITS * CLK_PER_BIT;
  localparam int CTRW = $clog2(STOP_CYC);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0] sr;
  logic [CTRW-1:0] ctr;
  logic [2:0] bit_ctr;
  logic block_q, wr, pop, bit_end, stop_end;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign busy = state != IDLE || count != '0;
  assign wr = new_data && !full;
  assign bit_end = ctr == CTRW'(CLK_PER_BIT - 1);
  assign stop_end = ctr == CTRW'(STOP_CYC - 1);
  assign pop = count != '0 && !block_q && (state == IDLE || (state == STOP && stop_end));
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      block_q <= 1'b0;
      sr <= '0;
      ctr <= '0;
      bit_ctr <= '0;
    end else begin
      block_q <= block;
      overflow <= new_data && full;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
      if (wr) wptr <= wptr + 1'b1;
      if (pop) begin
        sr <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case (state)
        IDLE: begin
          ctr <= '0;
          tx <= !pop;
          if (pop) state <= START;
        end
        START: if (bit_end) begin
          ctr <= '0;
          bit_ctr <= '0;
          state <= DATA;
          tx <= sr[0];
        end else ctr <= ctr + 1'b1;
        DATA: if (bit_end) begin
          ctr <= '0;
          if (bit_ctr == 3'd7) begin
            state <= STOP;
            tx <= 1'b1;
          end else begin
            bit_ctr <= bit_ctr + 1'b1;
            tx <= sr[bit_ctr + 3'd1];
          end
        end else ctr <= ctr + 1'b1;
        STOP: if (stop_end) begin
          ctr <= '0;
          state <= pop ? START : IDLE;
          tx <= !pop;
        end else ctr <= ctr + 1'b1;
        default: begin
          state <= IDLE;
          tx <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_tx_buffered.md
Name: serial_tx_buffered

Overview:
- UART transmitter with 8N1 framing by default and a configurable stop-bit count.
- It is the transmit end of the card's serial debug/command link, paired with the existing serial receiver at the same CLK_PER_BIT.
- Bytes are written into an internal FIFO with a one-cycle strobe, then serialized LSB-first on tx back-to-back.
- A block input holds off new frames, for host flow control.

Parameters:
- CLK_PER_BIT, 50, clock cycles per bit period. Must be >= 2.
- FIFO_DEPTH, 16, number of FIFO entries. Power of two, >= 2.
- STOP_BITS, 1, number of stop bit periods. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- data  input  8  byte to enqueue. Sampled when new_data=1.
- new_data  input  1  one-cycle write strobe.
- block  input  1  when high, no new frame starts. A frame in progress always completes.
- tx  output  1  serial line. Idle high.
- busy  output  1  high when state != IDLE or the FIFO is non-empty.
- full  output  1  FIFO count == FIFO_DEPTH.
- count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset values: tx=1, busy=0, full=0, count=0, overflow=0. State=IDLE, FIFO pointers=0.
- Reset mid-frame: tx is high after the reset edge, the FIFO is flushed, and the current frame is aborted.
- FIFO write: on an edge with new_data=1 and full=0, store data and increment count.
  - If full=1, the byte is dropped and overflow=1 on the next cycle.
  - Full is evaluated on the registered count. A write is dropped even if a pop happens on the same edge.
- Simultaneous write and pop (not full): count is unchanged and both take effect.
- Pointers wrap modulo FIFO_DEPTH.
- block is registered once (block_q). Start decisions use block_q only.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If count>0 and block_q=0: pop the head into shift register sr, set ctr=0, go to START, and drive tx=0 on the same edge.
- START:
  - tx=0 for CLK_PER_BIT cycles.
  - At ctr==CLK_PER_BIT-1: ctr=0, bit_ctr=0, go to DATA, tx=sr[0].
- DATA:
  - tx=sr[bit_ctr] for CLK_PER_BIT cycles per bit, LSB first.
  - At ctr==CLK_PER_BIT-1: if bit_ctr==7, go to STOP with tx=1; otherwise bit_ctr+1.
- STOP:
  - tx=1 for STOP_BITS*CLK_PER_BIT cycles.
  - At the end: if count>0 and block_q=0, pop and go directly to START (tx=0), giving no idle gap. Otherwise go to IDLE.
- tx is a registered output, glitch-free.
- Latency: a byte written at edge N into an idle, empty block drives tx low from edge N+1.
- Frame length: exactly (9+STOP_BITS)*CLK_PER_BIT cycles. Back-to-back frame period is the same value.
- block rising mid-frame: the current frame completes and the next start is suppressed while block_q=1. Release resumes with 1 cycle of block_q latency.
- ctr width is $clog2(STOP_BITS*CLK_PER_BIT).
- Illegal state encodings return to IDLE with tx=1.

Test Plan:
- Single byte:
  - Stimulus: CLK_PER_BIT=4, write 0xA5 while idle.
  - Required response: tx falls 1 edge later. Per 4 clocks, tx reads 0,1,0,1,0,0,1,0,1,1 (start, bits LSB-first, stop).
  - Afterwards busy=0 and count=0, with busy low 40 cycles after tx falls.
- Back-to-back:
  - Stimulus: write 0x00, 0xFF, 0x55 on consecutive cycles.
  - Required response: count peaks at 2 because the first byte pops immediately.
  - Three frames follow with no idle cycles, 120 cycles total at CLK_PER_BIT=4.
- Overflow:
  - Stimulus: set block=1, then write 17 bytes 0x00..0x10.
  - Required response: after the 16th write full=1 and count=16. The 17th write produces an overflow pulse and count stays 16.
  - Release block: bytes 0x00..0x0F are transmitted in order and 0x10 is never sent.
- Flow control:
  - Stimulus: assert block mid-DATA of frame 1 with 2 bytes queued.
  - Required response: frame 1 completes, tx stays high while block=1, and frame 2 starts 2 edges after block falls.
- Reset mid-frame:
  - Stimulus: assert rst during DATA bit 3 with 3 bytes queued.
  - Required response: the next edge gives tx=1, count=0, busy=0. A new write then transmits normally.
- STOP_BITS=2:
  - Stimulus: CLK_PER_BIT=4, two queued bytes.
  - Required response: the stop high period is 8 cycles and the frame period is 44 cycles.
